// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-controller state encoding and default bus/wait sizes.
package cpu_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DATA_W_DEF      = 32;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP,
    WR_ISSUE,
    WR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/mem_wait_cnt.sv
// Wait-state down-counter: loaded when an access leaves its issue state; last is high on the final wait cycle.
module mem_wait_cnt #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller between the CPU datapath (MAR/MDR) and a synchronous 1-cycle-latency RAM.
// Optional wait states are enabled by defining MEM_WAIT_EN.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDRdata,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output state_t            dbg_state
);

  // Request protocol: a rising edge on Read or Write while Busy=0 starts exactly one
  // access; Done pulses for one cycle when it completes. Edges seen while Busy=1 are dropped.

`ifdef MEM_WAIT_EN
  localparam int WAITS = WAIT_CYCLES;
`else
  localparam int WAITS = WAIT_CYCLES * 0;
`endif
  localparam int CNT_W = (WAITS > 1) ? $clog2(WAITS) : 1;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              read_q;
  logic              write_q;
  logic              armed;
  logic              req_rd;
  logic              req_wr;

  // armed stays low for the first edge after reset so a level held across release is not an edge.
  assign req_rd = armed & Read & ~read_q;
  assign req_wr = armed & Write & ~write_q;

`ifdef MEM_WAIT_EN
  logic wait_last;
  logic wait_load;

  assign wait_load = (state == RD_ISSUE) || (state == WR_ISSUE);

  mem_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_wait_cnt (
    .clk  (Clock),
    .rst_n(Reset),
    .load (wait_load),
    .value(CNT_W'((WAITS > 0) ? WAITS - 1 : 0)),
    .last (wait_last)
  );
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req_rd && !req_wr) begin
          nxt = RD_ISSUE;
        end else if (req_wr && !req_rd) begin
          nxt = WR_ISSUE;
        end
      end
      RD_ISSUE: nxt = (WAITS > 0) ? RD_WAIT : RD_CAP;
      RD_CAP:   nxt = DONE;
      WR_ISSUE: nxt = (WAITS > 0) ? WR_WAIT : DONE;
`ifdef MEM_WAIT_EN
      RD_WAIT:  if (wait_last) nxt = RD_CAP;
      WR_WAIT:  if (wait_last) nxt = DONE;
`endif
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      mar       <= '0;
      mdr       <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      armed     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state   <= nxt;
      read_q  <= Read;
      write_q <= Write;
      armed   <= 1'b1;
      Busy    <= (nxt != IDLE);
      Done    <= (nxt == DONE);
      Err     <= (state == IDLE) && req_rd && req_wr;
      ram_re  <= (nxt == RD_ISSUE) || (nxt == RD_WAIT);
      ram_we  <= (nxt == WR_ISSUE) || (nxt == WR_WAIT);
      // Address/data are latched once at access start, so a same-edge MARin/MDRin cannot leak in.
      if (state == IDLE && nxt != IDLE) begin
        ram_addr  <= mar;
        ram_wdata <= mdr;
      end
      if (state == RD_CAP) begin
        mdr <= ram_rdata;
      end else if (!Busy && MDRin) begin
        mdr <= BusMuxOut;
      end
      if (!Busy && MARin) begin
        mar <= BusMuxOut[ADDR_W-1:0];
      end
    end
  end

  assign MDRdata   = mdr;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: transaction-level timing model plus directed scenarios.
module tb_mem_ctrl;
  import cpu_pkg::*;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_EN
  localparam int W = WAIT_CYCLES;
  localparam int EXP_RD_OFF = 5;
  localparam int EXP_WR_OFF = 4;
  localparam int EXP_PULSE  = 3;
`else
  localparam int W = 0;
  localparam int EXP_RD_OFF = 3;
  localparam int EXP_WR_OFF = 2;
  localparam int EXP_PULSE  = 1;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              Reset = 1'b0;
  logic [DATA_W-1:0] BusMuxOut = '0;
  logic              MARin = 1'b0;
  logic              MDRin = 1'b0;
  logic              Read = 1'b0;
  logic              Write = 1'b0;
  logic [DATA_W-1:0] MDRdata;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  state_t            dbg_state;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .Clock(clk),
    .Reset(Reset),
    .BusMuxOut(BusMuxOut),
    .MARin(MARin),
    .MDRin(MDRin),
    .Read(Read),
    .Write(Write),
    .MDRdata(MDRdata),
    .Busy(Busy),
    .Done(Done),
    .Err(Err),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_re(ram_re),
    .ram_rdata(ram_rdata),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int i);
    case (i)
      'h055:   return 32'hDEADBEEF;
      'h010:   return 32'hCAFE0001;
      'h0AA:   return 32'hBAD000AA;
      default: return 32'h5A000000 | DATA_W'(i);
    endcase
  endfunction

  // ---------------- synchronous RAM, 1-cycle read latency ----------------
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram[ram_addr];
    end
  end

  // ---------------- behavioural model ----------------
  // One access at a time: it occupies cycles [start, start+len] after its request edge,
  // the RAM strobe covers the first 1+W of them and Done the last.
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic              exp_ready = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic              m_active = 1'b0;
  logic              m_is_rd = 1'b0;
  int                m_start = 0;
  int                m_len = 0;
  int                m_err_cyc = -1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic [ADDR_W-1:0] m_mar = '0;
  logic [DATA_W-1:0] m_mdr = '0;
  logic              m_fresh = 1'b1;
  logic              m_prev_rd = 1'b0;
  logic              m_prev_wr = 1'b0;

  always @(posedge clk or negedge Reset) begin
    if (!exp_ready) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);
      exp_ready = 1'b1;
    end
    if (!Reset) begin
      m_active  = 1'b0;
      m_mar     = '0;
      m_mdr     = '0;
      m_fresh   = 1'b1;
      m_err_cyc = -1;
      m_prev_rd = 1'b0;
      m_prev_wr = 1'b0;
      exp_q.delete();
    end else begin
      int e;
      logic busy_prev, rd_edge, wr_edge;
      logic [ADDR_W-1:0] old_mar;
      logic [DATA_W-1:0] old_mdr;
      e = cyc + 1;
      busy_prev = m_active && (e - 1) >= m_start && (e - 1) <= m_start + m_len;
      rd_edge = !m_fresh && Read && !m_prev_rd;
      wr_edge = !m_fresh && Write && !m_prev_wr;
      if (m_active && m_is_rd && e == m_start + m_len && exp_q.size() > 0)
        m_mdr = exp_q.pop_front();
      if (!busy_prev) begin
        old_mar = m_mar;
        old_mdr = m_mdr;
        if (MARin) m_mar = BusMuxOut[ADDR_W-1:0];
        if (MDRin) m_mdr = BusMuxOut;
        if (rd_edge && wr_edge) begin
          m_err_cyc = e;
        end else if (rd_edge || wr_edge) begin
          m_active = 1'b1;
          m_is_rd  = rd_edge;
          m_start  = e;
          m_addr   = old_mar;
          m_data   = old_mdr;
          m_len    = rd_edge ? 2 + W : 1 + W;
          if (rd_edge) exp_q.push_back(exp_mem[old_mar]);
          else exp_mem[old_mar] = old_mdr;
        end
      end
      m_prev_rd = Read;
      m_prev_wr = Write;
      m_fresh   = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      logic e_busy, e_access, e_done, e_err;
      e_busy   = m_active && cyc >= m_start && cyc <= m_start + m_len;
      e_access = m_active && cyc >= m_start && cyc <= m_start + W;
      e_done   = m_active && cyc == m_start + m_len;
      e_err    = (cyc == m_err_cyc);
      check("busy", Busy, e_busy);
      check("done", Done, e_done);
      check("err", Err, e_err);
      check("ram_re", ram_re, e_access && m_is_rd);
      check("ram_we", ram_we, e_access && !m_is_rd);
      check("mdr", MDRdata, m_mdr);
      if (e_access) check("ram_addr", ram_addr, m_addr);
      if (e_access && !m_is_rd) check("ram_wdata", ram_wdata, m_data);
    end
  end

  // ---------------- event counters for the literal checks ----------------
  int re_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, last_done = 0;

  always @(negedge clk) begin
    if (ram_re === 1'b1) re_cnt++;
    if (ram_we === 1'b1) we_cnt++;
    if (Err === 1'b1) err_cnt++;
    if (Busy === 1'b1) busy_cnt++;
    if (Done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  int req_edge = 0;
  int b_re, b_we, b_done, b_err, b_busy;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_re = re_cnt; b_we = we_cnt; b_done = done_cnt; b_err = err_cnt; b_busy = busy_cnt;
  endtask

  task automatic set_mar(input logic [DATA_W-1:0] v);
    step(); BusMuxOut = v; MARin = 1'b1;
    step(); MARin = 1'b0;
  endtask

  task automatic set_mdr(input logic [DATA_W-1:0] v);
    step(); BusMuxOut = v; MDRin = 1'b1;
    step(); MDRin = 1'b0;
  endtask

  task automatic pulse_read();
    step(); Read = 1'b1; req_edge = cyc + 1;
    step(); Read = 1'b0;
  endtask

  task automatic pulse_write();
    step(); Write = 1'b1; req_edge = cyc + 1;
    step(); Write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (Busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", (n < budget), 1'b1);
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // reset state
    repeat (3) step();
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_re", ram_re, 1'b0);
    check("rst_we", ram_we, 1'b0);
    check("rst_addr", ram_addr, 9'h000);
    check("rst_mdr", MDRdata, 32'h0);
    check("rst_state", dbg_state, IDLE);
    Reset = 1'b1;
    repeat (2) step();

    // basic read
    set_mar(32'h055);
    snap();
    pulse_read();
    wait_idle(20);
    check("rd_data", MDRdata, 32'hDEADBEEF);
    check("rd_re_cycles", re_cnt - b_re, EXP_PULSE);
    check("rd_done_cnt", done_cnt - b_done, 1);
    check("rd_done_off", last_done - req_edge + 1, EXP_RD_OFF);

    // basic write
    set_mar(32'h1FF);
    set_mdr(32'h12345678);
    snap();
    pulse_write();
    wait_idle(20);
    check("wr_ram", ram[9'h1FF], 32'h12345678);
    check("wr_we_cycles", we_cnt - b_we, EXP_PULSE);
    check("wr_re_cycles", re_cnt - b_re, 0);
    check("wr_done_off", last_done - req_edge + 1, EXP_WR_OFF);

    // simultaneous request
    snap();
    step(); Read = 1'b1; Write = 1'b1;
    step(); Read = 1'b0; Write = 1'b0;
    repeat (3) step();
    check("sim_err_cnt", err_cnt - b_err, 1);
    check("sim_re", re_cnt - b_re, 0);
    check("sim_we", we_cnt - b_we, 0);
    check("sim_busy", busy_cnt - b_busy, 0);

    // busy protection: MARin and a Write edge during a read are dropped
    set_mar(32'h010);
    set_mdr(32'h0);
    snap();
    pulse_read();
    BusMuxOut = 32'h0AA; MARin = 1'b1; Write = 1'b1;
    step(); MARin = 1'b0; Write = 1'b0;
    wait_idle(20);
    check("bp_done_cnt", done_cnt - b_done, 1);
    check("bp_we", we_cnt - b_we, 0);
    check("bp_data", MDRdata, 32'hCAFE0001);
    set_mdr(32'h0);
    pulse_read();
    wait_idle(20);
    check("bp_mar_kept", MDRdata, 32'hCAFE0001);

    // MARin on the request edge: access uses the old MAR, MAR updates afterwards
    set_mdr(32'h0);
    step(); BusMuxOut = 32'h0AA; MARin = 1'b1; Read = 1'b1; req_edge = cyc + 1;
    step(); MARin = 1'b0; Read = 1'b0;
    wait_idle(20);
    check("same_edge_old_mar", MDRdata, 32'hCAFE0001);
    pulse_read();
    wait_idle(20);
    check("same_edge_new_mar", MDRdata, 32'hBAD000AA);

    // reset in RD_CAP with Read held across release
    snap();
    pulse_read();
    repeat (1 + W) step();
    check("mid_in_cap_busy", Busy, 1'b1);
    Read = 1'b1;
    Reset = 1'b0;
    #1;
    check("mid_busy", Busy, 1'b0);
    check("mid_done", Done, 1'b0);
    check("mid_re", ram_re, 1'b0);
    check("mid_addr", ram_addr, 9'h000);
    check("mid_mdr", MDRdata, 32'h0);
    check("mid_state", dbg_state, IDLE);
    repeat (2) step();
    Reset = 1'b1;
    snap();
    repeat (6) step();
    check("held_read_re", re_cnt - b_re, 0);
    check("held_read_busy", busy_cnt - b_busy, 0);
    check("held_read_done", done_cnt - b_done, 0);
    Read = 1'b0;
    step();

    // a fresh edge after reset works again (MAR was cleared to 0)
    snap();
    pulse_read();
    wait_idle(20);
    check("post_rst_done", done_cnt - b_done, 1);
    check("post_rst_data", MDRdata, 32'h5A000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete, actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, word-address width of MAR and the RAM port.
REQ-002 SHALL have parameter DATA_W, default 32, width of the data bus, MDR and RAM data.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, number of extra read/write wait states (used only under MEM_WAIT_EN).
REQ-004 SHALL have port Clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port BusMuxOut  in  DATA_W  datapath bus.
REQ-007 SHALL have port MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
REQ-008 SHALL have port MDRin  in  1  load MDR from BusMuxOut.
REQ-009 SHALL have port Read  in  1  read request from the control unit; its rising edge starts an access.
REQ-010 SHALL have port Write  in  1  write request from the control unit; its rising edge starts an access.
REQ-011 SHALL have port MDRdata  out  DATA_W  current MDR contents.
REQ-012 SHALL have port Busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL have port Done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port Err  out  1  one-cycle pulse flagging a simultaneous Read/Write request.
REQ-015 SHALL have ports ram_addr out ADDR_W, ram_wdata out DATA_W, ram_we out 1, ram_re out 1, ram_rdata in DATA_W; the RAM is synchronous, with 1-cycle read latency.

Function
REQ-016 SHALL use FSM states IDLE, RD_ISSUE, RD_WAIT, RD_CAP, WR_ISSUE, WR_WAIT, DONE.
REQ-017 SHALL detect request edges using registered copies of Read and Write: req_rd = Read & ~Read_q, req_wr = Write & ~Write_q.
REQ-018 SHALL, in IDLE, on req_rd only, go to RD_ISSUE; on req_wr only, go to WR_ISSUE.
REQ-019 SHALL, in IDLE, on req_rd and req_wr in the same cycle, start no access, stay in IDLE, and pulse Err high for the next cycle.
REQ-020 SHALL ignore request edges that occur while Busy=1; there is no queuing, and such edges are lost.
REQ-021 SHALL, in RD_ISSUE, drive ram_re=1 and ram_addr=MAR, then go to RD_WAIT when waits are enabled and nonzero, else to RD_CAP.
REQ-022 SHALL, in RD_CAP, load MDR from ram_rdata at the closing edge and then go to DONE.
REQ-023 SHALL, in WR_ISSUE, drive ram_we=1, ram_addr=MAR and ram_wdata=MDR, then go to WR_WAIT or DONE.
REQ-024 SHALL, in DONE, assert Done=1 for exactly one cycle and then return to IDLE.
REQ-025 SHALL, with no waits, assert Done in the 3rd cycle after the request-sampling edge for reads and in the 2nd cycle for writes.
REQ-026 SHALL keep ram_re and ram_we low in every state other than those named above, and never assert both.
REQ-027 SHALL honour MARin and MDRin only when Busy=0; while Busy=1 both are ignored, keeping address and data stable.
REQ-028 SHALL give MARin and MDRin in the same IDLE cycle as a request edge effect at that edge, so the access uses the old MAR/MDR values.

Reset
REQ-029 SHALL, on Reset low, immediately force state=IDLE, MAR=0, MDR=0, Read_q=Write_q=0, Busy=0, Done=0, Err=0, ram_re=0, ram_we=0, ram_addr=0 and ram_wdata=0.
REQ-030 SHALL abandon an access in progress when Reset is asserted mid-access; that access produces no Done.
REQ-031 SHALL NOT let a Read or Write held high across reset release start an access; only a new rising edge does.

Configuration
REQ-032 SHALL, with MEM_WAIT_EN defined, spend WAIT_CYCLES cycles in RD_WAIT or WR_WAIT, counted by a down-counter loaded on entry, holding ram_re/ram_we asserted throughout the wait.
REQ-033 SHALL, without MEM_WAIT_EN, omit RD_WAIT, WR_WAIT and the counter and ignore WAIT_CYCLES; WAIT_CYCLES=0 with the macro defined SHALL behave identically.

Structure
REQ-034 SHALL take the state enum, the ADDR_W/DATA_W defaults and the WAIT_CYCLES default from shared package cpu_pkg.
REQ-035 SHALL implement the wait counter as sub-module mem_wait_cnt, instantiated only under MEM_WAIT_EN.

Verification
REQ-036 SHALL check a basic read: MAR=0x055, RAM[0x055]=0xDEADBEEF, Read edge -> ram_re high for 1 cycle, Done pulse 3 cycles later, MDRdata=0xDEADBEEF.
REQ-037 SHALL check a basic write: MAR=0x1FF, MDR=0x12345678, Write edge -> one ram_we pulse with addr 0x1FF and data 0x12345678, Done 2 cycles later.
REQ-038 SHALL check a simultaneous request: Read and Write rising together -> Err pulse for 1 cycle, no ram_re/ram_we, Busy stays 0.
REQ-039 SHALL check busy protection: during a read, assert MARin with bus 0x0AA and pulse Write -> MAR unchanged, no write, only one Done.
REQ-040 SHALL check reset mid-read: Reset low in RD_CAP -> all outputs 0 at once, no Done; Read held high after release -> no access.
REQ-041 SHALL check wait states: with MEM_WAIT_EN and WAIT_CYCLES=2, read -> ram_re high for 3 cycles and Done 5 cycles after the request.
